decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl.sv | 113 +++++++++++
 tb/tb_decode_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// decode_ctrl: RV32I immediate/format decode feeding a 2-entry in-order skid buffer toward execute.
module decode_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc,
  output logic                   if_ready,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   id_valid,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_imm,
  output logic [2:0]             id_imm_sel,
  output logic [4:0]             id_rs1,
  output logic [4:0]             id_rs2,
  output logic [4:0]             id_rd,
  output logic                   id_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } entry_t;
  state_t                 state_q, state_d;
  entry_t                 head_q, head_d, skid_q, skid_d, new_e, out_e;
  logic                   if_ready_q;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [6:0]             op;
  logic [31:0]            in;
  logic                   accept, consume;
  assign in       = if_instr;
  assign op       = in[6:0];
  assign if_ready = if_ready_q;
  assign id_valid = state_q != EMPTY;
  assign accept   = if_valid & if_ready_q;
  assign consume  = id_valid & ex_ready;
  always_comb begin
    new_e     = '0;
    new_e.pc  = if_pc;
    new_e.rs1 = in[19:15];
    new_e.rs2 = in[24:20];
    new_e.rd  = in[11:7];
    new_e.sel = op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011} ? 3'd0 :
                op == 7'b0100011                 ? 3'd1 :
                op == 7'b1100011                 ? 3'd2 :
                op inside {7'b0110111, 7'b0010111} ? 3'd3 :
                op == 7'b1101111                 ? 3'd4 :
                op == 7'b0110011                 ? 3'd5 : 3'd7;
    new_e.ill = new_e.sel == 3'd7;
    new_e.imm = new_e.sel == 3'd0 ? {{20{in[31]}}, in[31:20]} :
                new_e.sel == 3'd1 ? {{20{in[31]}}, in[31:25], in[11:7]} :
                new_e.sel == 3'd2 ? {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0} :
                new_e.sel == 3'd3 ? {in[31:12], 12'b0} :
                new_e.sel == 3'd4 ? {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0} : 32'b0;
  end
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) state_d = EMPTY;
    else case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        head_d  = new_e;
      end
      ONE: if (accept && !consume) begin
        state_d = TWO;
        skid_d  = new_e;
      end else if (consume && !accept) state_d = EMPTY;
      else if (accept) head_d = new_e;
      TWO: if (consume) begin
        state_d = ONE;
        head_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  assign stall_d = (id_valid && !ex_ready && !(&stall_q)) ? stall_q + STALL_CNT_W'(1) : stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      if_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      if_ready_q <= state_d != TWO;
      stall_q    <= stall_d;
    end
  end
  // Stale head contents are masked so consumers only ever see zeros when nothing is offered.
  assign out_e      = id_valid ? head_q : '0;
  assign id_pc      = out_e.pc;
  assign id_imm     = out_e.imm;
  assign id_imm_sel = out_e.sel;
  assign id_illegal = out_e.ill;
  assign id_rs1     = out_e.rs1;
  assign id_rs2     = out_e.rs2;
  assign id_rd      = out_e.rd;
  assign stall_cnt  = stall_q;
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed checks of decode_ctrl immediates, buffering, flush, stall count and reset.
module tb_decode_ctrl;
  logic        clk = 0, rst = 1, if_valid = 0, flush = 0, ex_ready = 0;
  logic [31:0] if_instr = 0, if_pc = 0;
  logic        if_ready, id_valid, id_illegal;
  logic [31:0] id_pc, id_imm;
  logic [2:0]  id_imm_sel;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  stall_cnt;
  int compared = 0, mismatched = 0;
  decode_ctrl #(.STALL_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_imm(id_imm), .id_imm_sel(id_imm_sel), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_illegal(id_illegal), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1;
    if_instr = instr;
    if_pc    = pc;
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    tick();
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_ready", 32'(if_ready), 1);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_imm", id_imm, 0);
    chk("rst_pc", id_pc, 0);
    ex_ready = 1;
    offer(32'hFFF00093, 32'h100);
    tick();
    chk("addi_valid", 32'(id_valid), 1);
    chk("addi_imm", id_imm, 32'hFFFFFFFF);
    chk("addi_sel", 32'(id_imm_sel), 0);
    chk("addi_rd", 32'(id_rd), 1);
    chk("addi_pc", id_pc, 32'h100);
    chk("addi_ill", 32'(id_illegal), 0);
    offer(32'hFE000EE3, 32'h104);
    tick();
    chk("beq_imm", id_imm, 32'hFFFFFFFC);
    chk("beq_sel", 32'(id_imm_sel), 2);
    chk("beq_pc", id_pc, 32'h104);
    offer(32'h008000EF, 32'h108);
    tick();
    chk("jal_imm", id_imm, 32'h8);
    chk("jal_sel", 32'(id_imm_sel), 4);
    chk("jal_rd", 32'(id_rd), 1);
    if_valid = 0;
    tick();
    chk("drain_valid", 32'(id_valid), 0);
    chk("drain_imm", id_imm, 0);
    chk("drain_rd", 32'(id_rd), 0);
    ex_ready = 0;
    offer(32'h123452B7, 32'h200);
    tick();
    chk("lui_imm", id_imm, 32'h12345000);
    chk("lui_sel", 32'(id_imm_sel), 3);
    chk("lui_rd", 32'(id_rd), 5);
    chk("lui_ready", 32'(if_ready), 1);
    offer(32'h00112623, 32'h204);
    tick();
    chk("full_ready", 32'(if_ready), 0);
    chk("full_imm", id_imm, 32'h12345000);
    chk("full_pc", id_pc, 32'h200);
    chk("full_stall", 32'(stall_cnt), 1);
    offer(32'h00000013, 32'h208);
    tick();
    chk("hold_imm", id_imm, 32'h12345000);
    chk("hold_sel", 32'(id_imm_sel), 3);
    chk("hold_ready", 32'(if_ready), 0);
    chk("hold_stall", 32'(stall_cnt), 2);
    if_valid = 0;
    ex_ready = 1;
    tick();
    chk("sw_imm", id_imm, 32'hC);
    chk("sw_sel", 32'(id_imm_sel), 1);
    chk("sw_pc", id_pc, 32'h204);
    chk("sw_rs1", 32'(id_rs1), 2);
    chk("sw_rs2", 32'(id_rs2), 1);
    chk("sw_ready", 32'(if_ready), 1);
    ex_ready = 0;
    offer(32'h00000013, 32'h208);
    tick();
    chk("two_ready", 32'(if_ready), 0);
    chk("two_stall", 32'(stall_cnt), 3);
    flush = 1;
    ex_ready = 1;
    offer(32'h00000013, 32'h20C);
    tick();
    chk("flush_valid", 32'(id_valid), 0);
    chk("flush_pc", id_pc, 0);
    chk("flush_stall", 32'(stall_cnt), 3);
    flush = 0;
    if_valid = 0;
    tick();
    chk("postflush_valid", 32'(id_valid), 0);
    chk("postflush_ready", 32'(if_ready), 1);
    offer(32'h0000007F, 32'h300);
    tick();
    chk("ill_flag", 32'(id_illegal), 1);
    chk("ill_sel", 32'(id_imm_sel), 7);
    chk("ill_imm", id_imm, 0);
    if_valid = 0;
    ex_ready = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 32'(stall_cnt), 15);
    chk("sat_pc", id_pc, 32'h300);
    chk("sat_ill", 32'(id_illegal), 1);
    rst = 1;
    tick();
    chk("rst2_stall", 32'(stall_cnt), 0);
    chk("rst2_valid", 32'(id_valid), 0);
    chk("rst2_ready", 32'(if_ready), 1);
    rst = 0;
    tick();
    chk("rst2_hold_valid", 32'(id_valid), 0);
    chk("rst2_hold_stall", 32'(stall_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
